// File: rtl/fp_unpacker.sv
// fp_unpacker: splits a packed IEEE-754 operand into sign, unbiased exponent,
// explicit-hidden-bit significand and class, normalizing denormals one bit per cycle.
module fp_unpacker (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] op,
    input  logic        P,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [11:0] exp,
    output logic [52:0] mant,
    output logic [3:0]  cls,
    output logic        snan,
    output logic [5:0]  nshift
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t      state_q, state_d;
    logic        sign_q, sign_d, snan_q, snan_d;
    logic [11:0] exp_q, exp_d;
    logic [52:0] mant_q, mant_d;
    logic [3:0]  cls_q, cls_d;
    logic [5:0]  nshift_q, nshift_d;
    logic [10:0] ef;
    logic        ef_max, ef_zero, frac_nz;
    logic [52:0] frac;
    logic [11:0] bias;
    // Single-precision fraction lands at mant[51:29] so both formats share one datapath.
    assign ef      = P ? {3'b0, op[62:55]} : op[62:52];
    assign ef_max  = P ? &op[62:55] : &op[62:52];
    assign ef_zero = ef == 11'd0;
    assign frac    = P ? {1'b0, op[54:32], 29'b0} : {1'b0, op[51:0]};
    assign frac_nz = |frac;
    assign bias    = P ? 12'd127 : 12'd1023;
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        snan_d   = snan_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        cls_d    = cls_q;
        nshift_d = nshift_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d   = op[63];
                nshift_d = 6'd0;
                mant_d   = frac;
                snan_d   = 1'b0;
                exp_d    = 12'd0;
                if (ef_max) begin
                    cls_d   = frac_nz ? 4'b1000 : 4'b0100;
                    snan_d  = frac_nz & ~frac[51];
                    state_d = DONE;
                end else if (ef_zero) begin
                    cls_d   = frac_nz ? 4'b0010 : 4'b0001;
                    exp_d   = frac_nz ? 12'd1 - bias : 12'd0;
                    state_d = frac_nz ? NORM : DONE;
                end else begin
                    cls_d   = 4'b0000;
                    mant_d  = frac | {1'b1, 52'b0};
                    exp_d   = {1'b0, ef} - bias;
                    state_d = DONE;
                end
            end
            NORM: begin
                mant_d   = mant_q << 1;
                exp_d    = exp_q - 12'd1;
                nshift_d = nshift_q + 6'd1;
                state_d  = mant_q[51] ? DONE : NORM;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            snan_q   <= 1'b0;
            exp_q    <= 12'd0;
            mant_q   <= 53'd0;
            cls_q    <= 4'd0;
            nshift_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            snan_q   <= snan_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            cls_q    <= cls_d;
            nshift_q <= nshift_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sign      = sign_q;
    assign exp       = exp_q;
    assign mant      = mant_q;
    assign cls       = cls_q;
    assign snan      = snan_q;
    assign nshift    = nshift_q;
endmodule

// File: tb/tb_fp_unpacker.sv
// tb_fp_unpacker: directed and randomized operands checked against an arithmetic reference model.
module tb_fp_unpacker;
    logic        clk, reset, in_valid, in_ready, P, out_valid, out_ready;
    logic        sign, snan;
    logic [63:0] op;
    logic [11:0] exp;
    logic [52:0] mant;
    logic [3:0]  cls;
    logic [5:0]  nshift;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        logic [11:0] e;
        logic [52:0] m;
        logic [3:0]  c;
        logic        sn;
        logic [5:0]  n;
        int          lat;
    } res_t;
    res_t ex;

    fp_unpacker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .P(P), .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exp(exp), .mant(mant), .cls(cls), .snan(snan), .nshift(nshift)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [63:0] o, input logic p);
        res_t r;
        int bias = p ? 127 : 1023;
        int emax = p ? 255 : 2047;
        int ef = p ? int'(o[62:55]) : int'(o[62:52]);
        logic [52:0] f = p ? {1'b0, o[54:32], 29'b0} : {1'b0, o[51:0]};
        int sh = 0;
        r.s = o[63]; r.e = '0; r.m = '0; r.c = '0; r.sn = 0; r.n = '0; r.lat = 1;
        if (ef == emax) begin
            if (f == 0) r.c = 4'b0100;
            else begin r.c = 4'b1000; r.m = f; r.sn = !f[51]; end
        end else if (ef == 0) begin
            if (f == 0) r.c = 4'b0001;
            else begin
                while (!f[52]) begin f = f << 1; sh++; end
                r.c = 4'b0010; r.m = f; r.n = 6'(sh); r.e = 12'(1 - bias - sh); r.lat = sh + 1;
            end
        end else begin
            r.m = f | (53'd1 << 52);
            r.e = 12'(ef - bias);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Capture expectation on the cycle before acceptance; check every cycle a result is held.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                chk("sign", sign, ex.s);
                chk("exp", exp, ex.e);
                chk("mant", mant, ex.m);
                chk("cls", cls, ex.c);
                chk("snan", snan, ex.sn);
                chk("nshift", nshift, ex.n);
                chk("in_ready_busy", in_ready, 0);
            end else if (in_valid && in_ready) ex = model(op, P);
        end
    end

    task automatic send(input logic [63:0] o, input logic p, input int lat_req);
        int lat;
        op = o; P = p; in_valid = 1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; op = {$urandom, $urandom}; P = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, lat_req);
    endtask

    task automatic release_out(input int holds);
        repeat (holds) begin
            in_valid = 1; op = {$urandom, $urandom}; P = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_word"}, {sign, snan, exp, cls, nshift}, 0);
        chk({tag, "_mant"}, mant, 0);
    endtask

    initial begin
        logic [63:0] rnd, o;
        logic p;
        int cat, lat;
        reset = 1; in_valid = 0; op = 0; P = 0; out_ready = 0;
        repeat (2) @(posedge clk); #1;
        chk_zero_outputs("reset");
        @(negedge clk) reset = 0;
        @(posedge clk); #1;

        send(64'h3FF0000000000000, 0, 1);
        chk("dp1_exp", exp, 12'h000); chk("dp1_mant", mant, 53'd1 << 52);
        chk("dp1_cls", cls, 0); chk("dp1_nshift", nshift, 0); chk("dp1_sign", sign, 0);
        release_out(0);

        send(64'h0000000000000001, 0, 53);
        chk("dpmin_exp", exp, 12'hBCE); chk("dpmin_mant", mant, 53'd1 << 52);
        chk("dpmin_cls", cls, 4'b0010); chk("dpmin_nshift", nshift, 52);
        release_out(5);

        send({32'h80000001, 32'hDEADBEEF}, 1, 24);
        chk("spmin_sign", sign, 1); chk("spmin_exp", exp, 12'hF6B);
        chk("spmin_mant", mant, 53'd1 << 52); chk("spmin_nshift", nshift, 23);
        release_out(0);

        send({32'h7F800001, 32'h12345678}, 1, 1);
        chk("snan_cls", cls, 4'b1000); chk("snan_bit", snan, 1); chk("snan_mant", mant, 53'd1 << 29);
        release_out(1);

        send(64'hFFF0000000000000, 0, 1);
        chk("inf_cls", cls, 4'b0100); chk("inf_sign", sign, 1); chk("inf_mant", mant, 0);
        release_out(0);

        send(64'h8000000000000000, 0, 1);
        chk("zero_cls", cls, 4'b0001); chk("zero_sign", sign, 1);
        release_out(0);

        op = 64'h1; P = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        #2 reset = 1;
        #1 chk_zero_outputs("abort");
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        send(64'h3FF0000000000000, 0, 1);
        chk("post_abort_mant", mant, 53'd1 << 52); chk("post_abort_cls", cls, 0);
        release_out(0);

        for (int i = 0; i < 300; i++) begin
            p = 1'($urandom);
            cat = $urandom % 5;
            rnd = {$urandom, $urandom};
            o = {$urandom, $urandom};
            if (p) begin
                o[54:32] = rnd[22:0];
                case (cat)
                    0: o[62:55] = 8'($urandom_range(1, 254));
                    1: begin o[62:55] = 0; o[54:32] = 0; end
                    2: begin o[62:55] = 8'hFF; o[54:32] = 0; end
                    3: begin o[62:55] = 8'hFF; if (o[54:32] == 0) o[40] = 1; end
                    default: begin
                        o[62:55] = 0;
                        o[54:32] = rnd[22:0] >> ($urandom % 23);
                        if (o[54:32] == 0) o[32] = 1;
                    end
                endcase
            end else begin
                o[51:0] = rnd[51:0];
                case (cat)
                    0: o[62:52] = 11'($urandom_range(1, 2046));
                    1: begin o[62:52] = 0; o[51:0] = 0; end
                    2: begin o[62:52] = 11'h7FF; o[51:0] = 0; end
                    3: begin o[62:52] = 11'h7FF; if (o[51:0] == 0) o[7] = 1; end
                    default: begin
                        o[62:52] = 0;
                        o[51:0] = rnd[51:0] >> ($urandom % 52);
                        if (o[51:0] == 0) o[0] = 1;
                    end
                endcase
            end
            lat = model(o, p).lat;
            send(o, p, lat);
            release_out($urandom % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
